// File: rtl/obstacle_spawner.sv
// obstacle_spawner
//   Turns the 5-bit LFSR word into timed obstacle spawn events. After a
//   random gap of MIN_GAP + rnd[4:3] game ticks a lane is chosen from
//   rnd[2:0]. The lane is bumped by one if it repeats the previous lane.
//   The event is then queued in a small show-ahead FIFO, which the
//   renderer/collision logic drains over a valid/ready handshake.
//
// Ports
//   clk          system clock
//   RESET        asynchronous, active-high reset
//   enable       game running; 0 pauses spawning (the FIFO still drains)
//   tick         one-clk-wide game tick pulse
//   rnd[4:0]     random word, sampled only in LOAD (gap) and SPAWN (lane)
//   spawn_lane   lane of the FIFO head entry, 0 when empty
//   spawn_valid  FIFO not empty
//   spawn_ready  consumer accepts the head entry
//   fifo_count   number of queued entries (0..FIFO_DEPTH)
//   overflow     sticky flag: a spawn was dropped on a full FIFO
module obstacle_spawner #(
  parameter int MIN_GAP    = 4,
  parameter int FIFO_DEPTH = 4   // power of 2; fifo_count is 3 bits, so at most 4
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       enable,
  input  logic       tick,
  input  logic [4:0] rnd,
  output logic [2:0] spawn_lane,
  output logic       spawn_valid,
  input  logic       spawn_ready,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_SPAWN
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] gap_cnt;
  logic [2:0] last_lane;

  logic       load_gap;
  logic       dec_gap;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic [2:0] new_lane;

  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (enable) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!enable)                     state_nxt = ST_IDLE;
        else if (tick && gap_cnt == 3'd1) state_nxt = ST_SPAWN;
      end
      // SPAWN always reloads the gap; enable is re-checked in WAIT.
      ST_SPAWN: state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (datapath controls)
  // ---------------------------------------------------------------------
  always_comb begin
    load_gap = (state == ST_LOAD);
    dec_gap  = (state == ST_WAIT) && enable && tick && (gap_cnt != 3'd1);
    push_req = (state == ST_SPAWN);
  end

  // Lane pick: a repeat of the previous lane moves one lane over (7 wraps to 0).
  always_comb begin
    new_lane = rnd[2:0];
    if (rnd[2:0] == last_lane) new_lane = rnd[2:0] + 3'd1;
  end

  // A full FIFO can still take a push when the head is popped on the same edge.
  assign pop     = spawn_valid && spawn_ready;
  assign push_ok = push_req && ((fifo_count != DEPTH_C) || pop);

  // ---------------------------------------------------------------------
  // Gap counter and lane history
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      gap_cnt   <= '0;
      last_lane <= '0;
    end else begin
      if (load_gap)     gap_cnt <= 3'(MIN_GAP) + {1'b0, rnd[4:3]};
      else if (dec_gap) gap_cnt <= gap_cnt - 3'd1;
      // A dropped spawn must not influence the next lane choice.
      if (push_ok)      last_lane <= new_lane;
    end
  end

  // ---------------------------------------------------------------------
  // Spawn FIFO
  // ---------------------------------------------------------------------
  // NOTE: the storage array is not reset; nothing reads it unless
  // fifo_count says the entry is live, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= new_lane;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  assign spawn_valid = (fifo_count != 3'd0);
  assign spawn_lane  = spawn_valid ? mem[rd_ptr] : 3'd0;

endmodule

// File: tb/tb_obstacle_spawner.sv
module tb_obstacle_spawner;

  logic       clk;
  logic       RESET;
  logic       enable;
  logic       tick;
  logic [4:0] rnd;
  logic [2:0] spawn_lane;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  obstacle_spawner #(.MIN_GAP(4), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .RESET       (RESET),
    .enable      (enable),
    .tick        (tick),
    .rnd         (rnd),
    .spawn_lane  (spawn_lane),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    RESET       = 1'b1;
    enable      = 1'b0;
    tick        = 1'b0;
    spawn_ready = 1'b0;
    rnd         = 5'd0;
    step();
    step();
    RESET = 1'b0;
  endtask

  // Entered while the DUT is in LOAD; leaves it in SPAWN.
  task automatic run_to_spawn(input logic [4:0] load_rnd);
    int gap;
    gap = 4 + int'(load_rnd[4:3]);
    rnd = load_rnd;
    step();                      // LOAD -> WAIT, gap loaded
    for (int g = 0; g < gap; g++) begin
      tick = 1'b0;
      step();
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  // Entered in SPAWN; the push edge, leaves the DUT in LOAD.
  task automatic push_cycle(input logic [4:0] spawn_rnd);
    rnd = spawn_rnd;
    step();
  endtask

  task automatic do_spawn(input logic [4:0] load_rnd, input logic [4:0] spawn_rnd);
    run_to_spawn(load_rnd);
    push_cycle(spawn_rnd);
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", spawn_valid); end
    checks++; if (spawn_lane !== 3'd0) begin errors++; $display("FAIL reset_lane: got %0d expected 0", spawn_lane); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  // Gap 4+2=6 ticks, lane 5; valid rises on the 2nd edge after the 6th tick.
  task automatic test_first_spawn();
    apply_reset();
    enable = 1'b1;
    step();                      // IDLE -> LOAD
    run_to_spawn(5'b10011);      // edge N sampled the 6th tick
    checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid: got %b expected 0", spawn_valid); end
    push_cycle(5'b00101);        // edge N+1
    checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", spawn_valid); end
    checks++; if (spawn_lane !== 3'd5) begin errors++; $display("FAIL first_lane: got %0d expected 5", spawn_lane); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL first_count: got %0d expected 1", fifo_count); end
  endtask

  // Continues from test_first_spawn: last_lane=5, one entry queued, DUT in LOAD.
  task automatic test_lane_collision();
    spawn_ready = 1'b1;          // consume each entry the cycle after it appears
    do_spawn(5'b00000, 5'b00101);
    checks++; if (spawn_lane !== 3'd6 || fifo_count !== 3'd1) begin errors++; $display("FAIL collide_5to6: got lane %0d count %0d expected lane 6 count 1", spawn_lane, fifo_count); end
    do_spawn(5'b00000, 5'b00110);
    checks++; if (spawn_lane !== 3'd7 || fifo_count !== 3'd1) begin errors++; $display("FAIL collide_6to7: got lane %0d count %0d expected lane 7 count 1", spawn_lane, fifo_count); end
    do_spawn(5'b00000, 5'b00111);
    checks++; if (spawn_lane !== 3'd0 || spawn_valid !== 1'b1) begin errors++; $display("FAIL collide_wrap: got lane %0d valid %b expected lane 0 valid 1", spawn_lane, spawn_valid); end

    apply_reset();
    enable = 1'b1;
    step();
    do_spawn(5'b00000, 5'b00000);
    checks++; if (spawn_lane !== 3'd1) begin errors++; $display("FAIL collide_after_reset: got %0d expected 1", spawn_lane); end
  endtask

  task automatic test_overflow();
    logic [2:0] cands [5];
    logic [2:0] exp_lanes [4];
    cands     = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2};
    exp_lanes = '{3'd1, 3'd3, 3'd5, 3'd7};
    apply_reset();
    enable = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      do_spawn(5'b00000, {2'b00, cands[i]});
      checks++; if (fifo_count !== 3'(i + 1)) begin errors++; $display("FAIL ovf_fill_count%0d: got %0d expected %0d", i, fifo_count, i + 1); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b expected 0", overflow); end
    do_spawn(5'b00000, {2'b00, cands[4]});
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end

    enable      = 1'b0;
    spawn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (spawn_valid !== 1'b1 || spawn_lane !== exp_lanes[i]) begin errors++; $display("FAIL ovf_drain%0d: got valid %b lane %0d expected valid 1 lane %0d", i, spawn_valid, spawn_lane, exp_lanes[i]); end
      step();
    end
    checks++; if (spawn_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL ovf_empty: got valid %b count %0d expected 0 0", spawn_valid, fifo_count); end
    spawn_ready = 1'b0;

    // last_lane must still be 7, so a candidate of 7 moves to 0.
    enable = 1'b1;
    step();
    do_spawn(5'b00000, 5'b00111);
    checks++; if (spawn_lane !== 3'd0 || fifo_count !== 3'd1) begin errors++; $display("FAIL ovf_last_lane: got lane %0d count %0d expected lane 0 count 1", spawn_lane, fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [2:0] exp_lanes [4];
    exp_lanes = '{3'd2, 3'd3, 3'd4, 3'd5};
    apply_reset();
    enable = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) do_spawn(5'b00000, 5'(i));
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_pre_count: got %0d expected 4", fifo_count); end
    run_to_spawn(5'b00000);
    spawn_ready = 1'b1;
    push_cycle(5'b00101);
    spawn_ready = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_pp_count: got %0d expected 4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pp_overflow: got %b expected 0", overflow); end
    enable      = 1'b0;
    spawn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (spawn_valid !== 1'b1 || spawn_lane !== exp_lanes[i]) begin errors++; $display("FAIL full_drain%0d: got valid %b lane %0d expected valid 1 lane %0d", i, spawn_valid, spawn_lane, exp_lanes[i]); end
      step();
    end
    spawn_ready = 1'b0;
  endtask

  task automatic test_disable_drain();
    logic [2:0] exp_counts [3];
    exp_counts = '{3'd2, 3'd1, 3'd0};
    apply_reset();
    enable = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) do_spawn(5'b00000, 5'(i));
    step();                      // LOAD -> WAIT
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL dis_pre_count: got %0d expected 3", fifo_count); end
    enable      = 1'b0;
    spawn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (fifo_count !== exp_counts[i]) begin errors++; $display("FAIL dis_drain%0d: got %0d expected %0d", i, fifo_count, exp_counts[i]); end
    end
    checks++; if (spawn_valid !== 1'b0 || spawn_lane !== 3'd0) begin errors++; $display("FAIL dis_empty: got valid %b lane %0d expected 0 0", spawn_valid, spawn_lane); end
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    checks++; if (spawn_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL dis_no_spawn: got valid %b count %0d expected 0 0", spawn_valid, fifo_count); end
    spawn_ready = 1'b0;
  endtask

  task automatic test_reset_midwait();
    apply_reset();
    enable = 1'b1;
    step();
    do_spawn(5'b00000, 5'b00001);
    do_spawn(5'b00000, 5'b00010);
    step();                      // LOAD -> WAIT, gap 4
    tick = 1'b1; step(); tick = 1'b0; step();
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rst_pre_count: got %0d expected 2", fifo_count); end
    #2;
    RESET  = 1'b1;
    enable = 1'b0;
    #1;                          // still before the next rising edge
    checks++; if (spawn_valid !== 1'b0 || spawn_lane !== 3'd0) begin errors++; $display("FAIL rst_async_head: got valid %b lane %0d expected 0 0", spawn_valid, spawn_lane); end
    checks++; if (fifo_count !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_async_count: got count %0d overflow %b expected 0 0", fifo_count, overflow); end
    step();
    RESET  = 1'b0;
    enable = 1'b1;
    step();                      // IDLE -> LOAD
    do_spawn(5'b00000, 5'b00000);
    checks++; if (spawn_lane !== 3'd1 || fifo_count !== 3'd1) begin errors++; $display("FAIL rst_restart: got lane %0d count %0d expected lane 1 count 1", spawn_lane, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_lane_collision();
    test_overflow();
    test_full_push_pop();
    test_disable_drain();
    test_reset_midwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
